// File: rtl/mdl_fifo_pkg.sv
// mdl_fifo_pkg
// Shared definitions for the FIFO controller slice: address/count width
// helpers for the default 16-entry configuration and a width function so
// that modules built with a different DEPTH can size their own pointers.
// No ports (package).

package mdl_fifo_pkg;

  localparam int DEFAULT_DEPTH = 16;
  localparam int ADDR_W        = $clog2(DEFAULT_DEPTH);
  localparam int CNT_W         = ADDR_W + 1;

  typedef logic [ADDR_W-1:0] fifo_ptr_t;
  typedef logic [CNT_W-1:0]  fifo_cnt_t;

  // Pointer width for an arbitrary power-of-two depth.
  function automatic int fifo_addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Occupancy width: one extra bit so that a completely full FIFO
  // (count == depth) is representable.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mdl_fifo_ptr.sv
// mdl_fifo_ptr
// Wrapping pointer register used for both the write and read side of the
// FIFO. The pointer is exactly W bits wide, so with a power-of-two depth
// it wraps from DEPTH-1 back to 0 by plain binary overflow.
//
// Ports:
//   clk  in   clock, rising edge
//   rst  in   synchronous active-high reset, forces pointer to 0
//   clr  in   synchronous clear (flush), forces pointer to 0
//   inc  in   advance pointer by one
//   ptr  out  current pointer value

module mdl_fifo_ptr
  import mdl_fifo_pkg::*;
#(
  parameter int W = ADDR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/mdl_fifo_ctrl.sv
// mdl_fifo_ctrl
// Synchronous FIFO controller driving the write and read ports of an
// external mdl_memory array. Converts a valid/ready push stream and a
// valid/ready pop stream into memory writes and reads, tracks occupancy,
// full/empty/almost-full status and a sticky high-water mark. Pop data is
// show-ahead: the head entry comes straight from the memory read port.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   flush               synchronous clear of pointers/count/hwm
//   in_valid/in_ready   push handshake, in_data is the push payload
//   out_valid/out_ready pop handshake, out_data is the head entry
//   mem_vld_in          memory write enable
//   mem_wr_addr         memory write address (write pointer)
//   mem_data_in         memory write data
//   mem_vld_out         memory read enable
//   mem_rd_addr         memory read address (read pointer)
//   mem_data_out        combinational memory read data
//   count               occupancy 0..DEPTH
//   full, empty, almost_full  status flags from registered count
//   hwm                 maximum count since the last reset or flush

module mdl_fifo_ctrl
  import mdl_fifo_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int WIDTH        = 8,
  parameter int AFULL_THRESH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     mem_vld_in,
  output logic [$clog2(DEPTH)-1:0] mem_wr_addr,
  output logic [WIDTH-1:0]         mem_data_in,
  output logic                     mem_vld_out,
  output logic [$clog2(DEPTH)-1:0] mem_rd_addr,
  input  logic [WIDTH-1:0]         mem_data_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   hwm
);

  localparam int AW = fifo_addr_w(DEPTH);
  localparam int CW = fifo_cnt_w(DEPTH);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);

  logic          push;
  logic          pop;
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] hwm_nxt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign empty       = (count == '0);
  assign full        = (count == DEPTH_C);
  assign almost_full = (count >= AFULL_C);

  // Handshakes are masked during reset and flush so that nothing is
  // accepted or consumed in a cycle whose state is being discarded.
  assign in_ready  = ~full  & ~rst & ~flush;
  assign out_valid = ~empty & ~rst & ~flush;

  assign push = in_valid  & in_ready;
  assign pop  = out_valid & out_ready;

  // Reads are only enabled when non-empty and writes only when not full,
  // so the memory's same-address write-through path is never exercised.
  assign mem_vld_in  = push;
  assign mem_wr_addr = wr_ptr;
  assign mem_data_in = in_data;
  assign mem_vld_out = ~empty;
  assign mem_rd_addr = rd_ptr;
  assign out_data    = mem_data_out;

  // Because push already includes flush/rst masking, the pointers only
  // need the explicit clear for the flush case itself.
  mdl_fifo_ptr #(.W(AW)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (push),
    .ptr (wr_ptr)
  );

  mdl_fifo_ptr #(.W(AW)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (pop),
    .ptr (rd_ptr)
  );

  // Simultaneous push and pop leave occupancy unchanged; the high-water
  // mark tracks the post-update count so it is never behind count.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
    hwm_nxt = (count_nxt > hwm) ? count_nxt : hwm;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
      hwm   <= '0;
    end else begin
      count <= count_nxt;
      hwm   <= hwm_nxt;
    end
  end

endmodule

// File: doc/mdl_fifo_ctrl.md
# mdl_fifo_ctrl

Synchronous FIFO controller that sits directly upstream of the team's `mdl_memory` storage array and drives its write and read ports. It converts a valid/ready push stream and a valid/ready pop stream into memory write and read transactions. It maintains circular write/read pointers, occupancy, full/empty/almost-full status, and a sticky high-water mark. Pop data is show-ahead: the head entry is presented combinationally from the memory read port whenever the FIFO is non-empty.

## Interface
- `DEPTH`, 16, number of entries; power of two, ≥ 2; must match the memory's `DEPTH`.
- `WIDTH`, 8, data width; must match the memory's `WIDTH`.
- `AFULL_THRESH`, 12, `almost_full` asserts when `count` ≥ this value; valid range 1..DEPTH.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous clear of FIFO contents; pointers only, memory contents untouched.
- `in_valid`  in  1  push request.
- `in_ready`  out  1  push accepted when `in_valid & in_ready`.
- `in_data`  in  WIDTH  push data.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  pop when `out_valid & out_ready`.
- `out_data`  out  WIDTH  head entry (= `mem_data_out`).
- `mem_vld_in`  out  1  memory write enable.
- `mem_wr_addr`  out  $clog2(DEPTH)  memory write address (= write pointer).
- `mem_data_in`  out  WIDTH  memory write data (= `in_data`).
- `mem_vld_out`  out  1  memory read enable.
- `mem_rd_addr`  out  $clog2(DEPTH)  memory read address (= read pointer).
- `mem_data_out`  in  WIDTH  combinational memory read data.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `full`, `empty`, `almost_full`  out  1 each  status.
- `hwm`  out  $clog2(DEPTH)+1  sticky maximum of `count` since the last reset or flush.

## Operation
- Definitions: `push = in_valid & in_ready`; `pop = out_valid & out_ready`.
- `in_ready = ~full & ~rst & ~flush`.
- `out_valid = ~empty & ~rst & ~flush`.
- `mem_vld_in = push`.
- `mem_vld_out = ~empty`.
- `empty = (count == 0)`; `full = (count == DEPTH)`; `almost_full = (count >= AFULL_THRESH)`.
- Because reads are disabled when empty and writes are blocked when full, the memory's same-address write-through bypass never fires.
- Pointer update: `wr_ptr` advances by 1 on push; `rd_ptr` advances by 1 on pop. Both are $clog2(DEPTH) bits wide and wrap modulo DEPTH naturally (DEPTH−1 → 0).
- Count update:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged, both pointers advance.
- Full: push blocked even if a pop happens in the same cycle. That cycle gives pop only, and the count becomes DEPTH−1.
- Empty: pop impossible. A push writes memory, and the data appears on `out_data` with `out_valid=1` in the next cycle.
- `hwm`: the next value is the larger of `hwm` and the next `count`.
- Flush (when `rst`=0): next state clears `wr_ptr`, `rd_ptr`, `count`, and `hwm` to 0. Push and pop are suppressed that cycle. `flush` has priority over push and pop.
- `rst` has priority over `flush`.

## Timing
- Reset values, in cycles with `rst`=1 and afterward until the first push:
  - `count`=0, `hwm`=0, `empty`=1, `full`=0, `almost_full`=0
  - `in_ready`=0 while `rst`=1 and 1 after; `out_valid`=0, `mem_vld_in`=0, `mem_vld_out`=0
  - `mem_wr_addr`=0, `mem_rd_addr`=0
- Push-to-pop latency: 1 cycle. Data pushed at edge N is visible on `out_data` after edge N.
- Sustained throughput: 1 push plus 1 pop per cycle at any occupancy 1..DEPTH−1.
- Status flags reflect registered `count` and change only on clock edges.
- `out_data` is combinational from `mem_rd_addr`. It is stable between edges as long as the FIFO is non-empty.
- Reset or flush mid-stream discards all entries on the same edge. Downstream must not rely on `out_data` in that cycle.

## Structure
- Shared package `mdl_fifo_pkg` holds:
  - `localparam` helpers for address width (`ADDR_W = $clog2(DEPTH)`) and count width (`ADDR_W+1`)
  - typedefs `fifo_ptr_t` and `fifo_cnt_t`, parameterised via a package function or sized by the instantiating module.
- One sub-module, `mdl_fifo_ptr`: a wrapping pointer register with `rst`, `clr`, and `inc` inputs. It is instantiated twice, for the write and read pointers.
- Integration wrapper `mdl_fifo` instantiates `mdl_fifo_ctrl` plus `mdl_memory`. Its port maps are exact by name (`mem_*` ↔ memory ports).

## Test plan
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles with `out_ready`=0 → `count`=3, `out_data`=0x11. Then pop ×3 → 0x11, 0x22, 0x33 in order, `empty`=1.
- Push 16 entries (0x00..0x0F) → `full`=1, `in_ready`=0, `almost_full` set at `count`=12. Then one push plus pop in the same cycle → pop only, `count`=15, the push data is not written.
- Continuous push and pop for 40 cycles with `count` held at 5 → pointers wrap past 15→0, `count` stays 5, pop order matches push order, `hwm`=5.
- Single push of 0xA5 into the empty FIFO → `out_valid`=0 in that cycle, 1 next cycle with `out_data`=0xA5.
- Fill to 9, then assert `flush` while `in_valid` and `out_ready` are high → next cycle `count`=0, `hwm`=0, `empty`=1, pointers 0, no memory write that cycle.
- Fill to 7, assert `rst` for 1 cycle with `in_valid`=1 → `in_ready`=0 during reset, then all outputs at reset values; a subsequent push of 0x5A reads back 0x5A.
